// File: rtl/dbg_seq.sv
// -----------------------------------------------------------------------------
// dbg_seq -- run-time sequencer for the debug tap's per-stage override enables.
//
// The block arms on a start command and waits for a selected pipeline event.
// It then drives the debug mux override enables (oenb_o) for a programmed
// number of cycles. During that window it counts aco_valid pulses and
// snapshots the first wake result. Configuration is latched on the start cycle
// only, so the logic-analyzer config bits may change freely during a run.
//
// Ports
//   clk_i            in   1        system clock
//   rst_n_i          in   1        asynchronous active-low reset
//   cmd_start_i      in   1        start a run (level, sampled each cycle)
//   cmd_abort_i      in   1        abort a run (level, highest priority)
//   cfg_mask_i       in   5        stage override mask (bit0 ctl .. bit4 wrd)
//   cfg_trig_sel_i   in   3        0 immediate, 1 dfe_valid, 2 aco_valid,
//                                  3 aco_last, 4 wrd_wake_valid, 5-7 never
//   cfg_hold_i       in   HOLD_BW  override window length in cycles
//   dfe_valid_i      in   1        pipeline event tap
//   aco_valid_i      in   1        pipeline event tap
//   aco_last_i       in   1        pipeline event tap
//   wrd_wake_i       in   1        pipeline wake value tap
//   wrd_wake_valid_i in   1        pipeline wake qualifier tap
//   oenb_o           out  5        override enables to the debug mux
//   busy_o           out  1        run in progress (ARMED or OVR)
//   done_o           out  1        run completed (sticky until start/abort)
//   aco_cnt_o        out  CNT_BW   saturating aco_valid count inside window
//   wake_seen_o      out  1        a wrd_wake_valid occurred inside window
//   wake_val_o       out  1        wrd_wake_i at the first such occurrence
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module dbg_seq #(
   parameter int HOLD_BW = 16,
   parameter int CNT_BW  = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               cmd_start_i,
   input  logic               cmd_abort_i,
   input  logic [4:0]         cfg_mask_i,
   input  logic [2:0]         cfg_trig_sel_i,
   input  logic [HOLD_BW-1:0] cfg_hold_i,
   input  logic               dfe_valid_i,
   input  logic               aco_valid_i,
   input  logic               aco_last_i,
   input  logic               wrd_wake_i,
   input  logic               wrd_wake_valid_i,
   output logic [4:0]         oenb_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [CNT_BW-1:0]  aco_cnt_o,
   output logic               wake_seen_o,
   output logic               wake_val_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_OVR   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_BW-1:0] CNT_MAX = {CNT_BW{1'b1}};

   state_t               state_q,     state_d;
   logic [4:0]           mask_q,      mask_d;
   logic [2:0]           trig_sel_q,  trig_sel_d;
   logic [HOLD_BW-1:0]   hold_q,      hold_d;
   logic [HOLD_BW-1:0]   remain_q,    remain_d;

   logic [4:0]           oenb_d;
   logic                 busy_d;
   logic                 done_d;
   logic [CNT_BW-1:0]    aco_cnt_d;
   logic                 wake_seen_d;
   logic                 wake_val_d;

   logic                 trig_hit;

   // ---------------------------------------------------------------------------
   // Trigger select, decoded from the latched selector so that mid-run config
   // changes cannot retarget an armed run.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first; a path that
      // leaves a signal unassigned would infer a latch.
      trig_hit = 1'b0;
      case (trig_sel_q)
         3'd0:    trig_hit = 1'b1;
         3'd1:    trig_hit = dfe_valid_i;
         3'd2:    trig_hit = aco_valid_i;
         3'd3:    trig_hit = aco_last_i;
         3'd4:    trig_hit = wrd_wake_valid_i;
         default: trig_hit = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      trig_sel_d  = trig_sel_q;
      hold_d      = hold_q;
      remain_d    = remain_q;
      aco_cnt_d   = aco_cnt_o;
      wake_seen_d = wake_seen_o;
      wake_val_d  = wake_val_o;

      if (cmd_abort_i) begin
         // Abort wins over start, trigger and window accounting. Status is
         // left untouched so software can still inspect a partial window.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (cmd_start_i) begin
                  mask_d      = cfg_mask_i;
                  trig_sel_d  = cfg_trig_sel_i;
                  hold_d      = cfg_hold_i;
                  aco_cnt_d   = '0;
                  wake_seen_d = 1'b0;
                  wake_val_d  = 1'b0;
                  state_d     = S_ARMED;
               end
            end

            S_ARMED: begin
               if (trig_hit) begin
                  // A zero-length window completes without ever driving
                  // the override enables.
                  if (hold_q == '0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d  = S_OVR;
                     remain_d = hold_q;
                  end
               end
            end

            S_OVR: begin
               if (aco_valid_i && (aco_cnt_o != CNT_MAX)) begin
                  aco_cnt_d = aco_cnt_o + 1'b1;
               end
               if (wrd_wake_valid_i && !wake_seen_o) begin
                  wake_seen_d = 1'b1;
                  wake_val_d  = wrd_wake_i;
               end
               // remain_q counts the OVR cycles still owed including this
               // one; reading 1 means this is the last window cycle. The
               // <= guard makes an unexpected 0 terminate instead of wrap.
               if (remain_q <= HOLD_BW'(1)) begin
                  state_d = S_DONE;
               end else begin
                  remain_d = remain_q - 1'b1;
               end
            end

            default: state_d = S_IDLE;
         endcase
      end

      // Outputs are registered versions of what the next state implies, so
      // they change on the same edge as the state register.
      oenb_d = (state_d == S_OVR) ? mask_d : 5'b0;
      busy_d = (state_d == S_ARMED) || (state_d == S_OVR);
      done_d = (state_d == S_DONE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         trig_sel_q  <= '0;
         hold_q      <= '0;
         remain_q    <= '0;
         oenb_o      <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         aco_cnt_o   <= '0;
         wake_seen_o <= 1'b0;
         wake_val_o  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         trig_sel_q  <= trig_sel_d;
         hold_q      <= hold_d;
         remain_q    <= remain_d;
         oenb_o      <= oenb_d;
         busy_o      <= busy_d;
         done_o      <= done_d;
         aco_cnt_o   <= aco_cnt_d;
         wake_seen_o <= wake_seen_d;
         wake_val_o  <= wake_val_d;
      end
   end

endmodule

// File: tb/tb_dbg_seq.sv
// -----------------------------------------------------------------------------
// tb_dbg_seq -- directed self-checking bench for dbg_seq.
//
// Each step pushes the expected output snapshot into a scoreboard queue, then
// advances the clock and pops/compares against the DUT outputs sampled 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dbg_seq;

   localparam int HOLD_BW = 16;
   localparam int CNT_BW  = 8;

   logic               clk_i = 1'b0;
   logic               rst_n_i;
   logic               cmd_start_i;
   logic               cmd_abort_i;
   logic [4:0]         cfg_mask_i;
   logic [2:0]         cfg_trig_sel_i;
   logic [HOLD_BW-1:0] cfg_hold_i;
   logic               dfe_valid_i;
   logic               aco_valid_i;
   logic               aco_last_i;
   logic               wrd_wake_i;
   logic               wrd_wake_valid_i;
   logic [4:0]         oenb_o;
   logic               busy_o;
   logic               done_o;
   logic [CNT_BW-1:0]  aco_cnt_o;
   logic               wake_seen_o;
   logic               wake_val_o;

   dbg_seq #(.HOLD_BW(HOLD_BW), .CNT_BW(CNT_BW)) dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .cmd_start_i      (cmd_start_i),
      .cmd_abort_i      (cmd_abort_i),
      .cfg_mask_i       (cfg_mask_i),
      .cfg_trig_sel_i   (cfg_trig_sel_i),
      .cfg_hold_i       (cfg_hold_i),
      .dfe_valid_i      (dfe_valid_i),
      .aco_valid_i      (aco_valid_i),
      .aco_last_i       (aco_last_i),
      .wrd_wake_i       (wrd_wake_i),
      .wrd_wake_valid_i (wrd_wake_valid_i),
      .oenb_o           (oenb_o),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .aco_cnt_o        (aco_cnt_o),
      .wake_seen_o      (wake_seen_o),
      .wake_val_o       (wake_val_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [4:0] oenb;
      logic       busy;
      logic       done;
      logic [7:0] cnt;
      logic       seen;
      logic       val;
   } out_t;

   typedef struct {
      string tag;
      out_t  v;
   } sb_entry_t;

   sb_entry_t sb[$];
   int        vectors     = 0;
   int        miscompares = 0;
   int        exp_cnt;
   logic      exp_seen;
   logic      exp_val;

   task automatic push(input string tag, input logic [4:0] oenb, input logic busy,
                       input logic done, input logic [7:0] cnt, input logic seen,
                       input logic val);
      sb_entry_t e;
      e.tag = tag;
      e.v   = {oenb, busy, done, cnt, seen, val};
      sb.push_back(e);
   endtask

   task automatic check();
      sb_entry_t e;
      out_t      obs;
      obs = {oenb_o, busy_o, done_o, aco_cnt_o, wake_seen_o, wake_val_o};
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: observed no expectation queued");
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            miscompares++;
            $error("FAIL %s: observed oenb=%b busy=%b done=%b cnt=%0d seen=%b val=%b, expected oenb=%b busy=%b done=%b cnt=%0d seen=%b val=%b",
                   e.tag, obs.oenb, obs.busy, obs.done, obs.cnt, obs.seen, obs.val,
                   e.v.oenb, e.v.busy, e.v.done, e.v.cnt, e.v.seen, e.v.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_n_i = 1'b0; cmd_start_i = 1'b0; cmd_abort_i = 1'b0;
      cfg_mask_i = '0; cfg_trig_sel_i = '0; cfg_hold_i = '0;
      dfe_valid_i = 1'b0; aco_valid_i = 1'b0; aco_last_i = 1'b0;
      wrd_wake_i = 1'b0; wrd_wake_valid_i = 1'b0;

      // Reset values.
      #12;
      push("reset", 5'b0, 0, 0, 0, 0, 0); check();
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      push("idle_after_reset", 5'b0, 0, 0, 0, 0, 0); tick(); check();

      // Immediate trigger, mask 01000, hold 3. Start held through the run and
      // config scrambled after the start cycle: neither may disturb the run.
      cfg_mask_i = 5'b01000; cfg_trig_sel_i = 3'd0; cfg_hold_i = 16'd3; cmd_start_i = 1'b1;
      push("t1_armed", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      cfg_mask_i = 5'b11111; cfg_hold_i = 16'd1; cfg_trig_sel_i = 3'd7;
      push("t1_ovr0", 5'b01000, 1, 0, 0, 0, 0); tick(); check();
      push("t1_ovr1", 5'b01000, 1, 0, 0, 0, 0); tick(); check();
      push("t1_ovr2", 5'b01000, 1, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0;
      push("t1_done", 5'b0, 0, 1, 0, 0, 0); tick(); check();
      push("t1_done_hold", 5'b0, 0, 1, 0, 0, 0); tick(); check();

      // aco_valid trigger, hold 10, pulses at window cycles 0,4,9. The trigger
      // pulse and a post-window pulse are excluded from the count.
      cfg_mask_i = 5'b00001; cfg_trig_sel_i = 3'd2; cfg_hold_i = 16'd10; cmd_start_i = 1'b1;
      push("t2_armed", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0; aco_valid_i = 1'b1;
      push("t2_ovr_entry", 5'b00001, 1, 0, 0, 0, 0); tick(); check();
      exp_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         aco_valid_i = (k == 0 || k == 4 || k == 9);
         if (k == 0 || k == 4 || k == 9) exp_cnt++;
         if (k < 9) push($sformatf("t2_win%0d", k), 5'b00001, 1, 0, 8'(exp_cnt), 0, 0);
         else       push("t2_done", 5'b0, 0, 1, 8'(exp_cnt), 0, 0);
         tick(); check();
      end
      aco_valid_i = 1'b1;
      push("t2_post_window", 5'b0, 0, 1, 8'd3, 0, 0); tick(); check();
      aco_valid_i = 1'b0;

      // dfe_valid trigger, hold 300, aco_valid held high: saturate at 255.
      cfg_mask_i = 5'b00010; cfg_trig_sel_i = 3'd1; cfg_hold_i = 16'd300; cmd_start_i = 1'b1;
      push("t3_armed_cleared", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0;
      tick(); tick();
      push("t3_armed_waits", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      dfe_valid_i = 1'b1; aco_valid_i = 1'b1;
      push("t3_ovr_entry", 5'b00010, 1, 0, 0, 0, 0); tick(); check();
      dfe_valid_i = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         if (i == 254 || i == 255 || i == 256 || i == 299) begin
            push($sformatf("t3_cnt_i%0d", i), 5'b00010, 1, 0, 8'((i > 255) ? 255 : i), 0, 0);
            tick(); check();
         end else if (i == 300) begin
            push("t3_done_sat", 5'b0, 0, 1, 8'd255, 0, 0);
            tick(); check();
         end else begin
            tick();
         end
      end
      aco_valid_i = 1'b0;

      // wrd_wake_valid trigger, hold 8: first in-window wake (1) wins, the
      // later one (0) and the trigger-cycle one (0) are ignored.
      cfg_mask_i = 5'b10000; cfg_trig_sel_i = 3'd4; cfg_hold_i = 16'd8; cmd_start_i = 1'b1;
      push("t4_armed_cleared", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0; wrd_wake_valid_i = 1'b1; wrd_wake_i = 1'b0;
      push("t4_ovr_entry", 5'b10000, 1, 0, 0, 0, 0); tick(); check();
      exp_seen = 1'b0; exp_val = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wrd_wake_valid_i = (k == 2 || k == 5);
         wrd_wake_i       = (k == 2);
         if (k == 2) begin exp_seen = 1'b1; exp_val = 1'b1; end
         if (k < 7) push($sformatf("t4_win%0d", k), 5'b10000, 1, 0, 0, exp_seen, exp_val);
         else       push("t4_done", 5'b0, 0, 1, 0, exp_seen, exp_val);
         tick(); check();
      end
      wrd_wake_valid_i = 1'b0; wrd_wake_i = 1'b0;

      // Abort from DONE: back to IDLE with status retained.
      cmd_abort_i = 1'b1;
      push("t4_abort_done", 5'b0, 0, 0, 0, 1, 1); tick(); check();
      cmd_abort_i = 1'b0;

      // Abort together with an immediate trigger in ARMED, then abort beating start.
      cfg_mask_i = 5'b11111; cfg_trig_sel_i = 3'd0; cfg_hold_i = 16'd4; cmd_start_i = 1'b1;
      push("t5_armed", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0; cmd_abort_i = 1'b1;
      push("t5_abort_armed", 5'b0, 0, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b1;
      push("t5_abort_beats_start", 5'b0, 0, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0; cmd_abort_i = 1'b0;

      // Abort mid-OVR: enables drop next edge, count retained.
      cfg_mask_i = 5'b00110; cfg_trig_sel_i = 3'd2; cfg_hold_i = 16'd20; cmd_start_i = 1'b1;
      push("t6_armed", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0; aco_valid_i = 1'b1;
      push("t6_ovr_entry", 5'b00110, 1, 0, 0, 0, 0); tick(); check();
      push("t6_ovr_cnt1", 5'b00110, 1, 0, 1, 0, 0); tick(); check();
      push("t6_ovr_cnt2", 5'b00110, 1, 0, 2, 0, 0); tick(); check();
      aco_valid_i = 1'b0; cmd_abort_i = 1'b1;
      push("t6_abort_ovr", 5'b0, 0, 0, 2, 0, 0); tick(); check();
      cmd_abort_i = 1'b0;
      push("t6_idle_retain", 5'b0, 0, 0, 2, 0, 0); tick(); check();

      // hold 0 with immediate trigger: DONE two edges after start, no override.
      cfg_mask_i = 5'b11111; cfg_trig_sel_i = 3'd0; cfg_hold_i = 16'd0; cmd_start_i = 1'b1;
      push("t7_armed", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0;
      push("t7_done", 5'b0, 0, 1, 0, 0, 0); tick(); check();
      push("t7_done_hold", 5'b0, 0, 1, 0, 0, 0); tick(); check();

      // Asynchronous reset in the middle of a window.
      cfg_mask_i = 5'b11111; cfg_trig_sel_i = 3'd0; cfg_hold_i = 16'd5; cmd_start_i = 1'b1;
      push("t8_armed", 5'b0, 1, 0, 0, 0, 0); tick(); check();
      cmd_start_i = 1'b0; aco_valid_i = 1'b1;
      push("t8_ovr_entry", 5'b11111, 1, 0, 0, 0, 0); tick(); check();
      push("t8_ovr_cnt1", 5'b11111, 1, 0, 1, 0, 0); tick(); check();
      #2;
      rst_n_i = 1'b0;
      #1;
      push("t8_async_reset", 5'b0, 0, 0, 0, 0, 0); check();
      aco_valid_i = 1'b0;
      push("t8_reset_held", 5'b0, 0, 0, 0, 0, 0); tick(); check();
      rst_n_i = 1'b1;
      push("t8_idle_after", 5'b0, 0, 0, 0, 0, 0); tick(); check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
